// File: rtl/arm_mem_pkg.sv
// Shared types for the MEM-stage SRAM responder.
// Holds FSM states and the fixed SRAM/word widths.
package arm_mem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOW,
    HIGH,
    DONE
  } state_e;

  localparam int unsigned SRAM_BASE_DEFAULT = 1024;
  localparam int unsigned HW_W = 16;
  localparam int unsigned WORD_W = 32;

endpackage

// File: rtl/sram_mem_responder.sv
// MEM-stage responder: splits each 32-bit access into two
// 16-bit async SRAM accesses with programmable wait states.
module sram_mem_responder
  import arm_mem_pkg::*;
#(
  parameter int unsigned SRAM_BASE   = SRAM_BASE_DEFAULT,
  parameter int unsigned WAIT_CYCLES = 2,
  parameter int unsigned SRAM_AW     = 18
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               MEM_R_EN,
  input  logic               MEM_W_EN,
  input  logic [WORD_W-1:0]  Address,
  input  logic [WORD_W-1:0]  Data,
  output logic [WORD_W-1:0]  MEM_result,
  output logic               ready,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic [HW_W-1:0]    sram_dq_out,
  output logic               sram_dq_oe,
  input  logic [HW_W-1:0]    sram_dq_in,
  output logic               sram_ce_n,
  output logic               sram_oe_n,
  output logic               sram_we_n
);

  localparam logic [3:0] LAST = 4'(WAIT_CYCLES - 1);

  state_e              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic                wr_q, wr_d;
  logic [SRAM_AW-2:0]  word_q, word_d;
  logic [WORD_W-1:0]   data_q, data_d;
  logic [WORD_W-1:0]   result_q, result_d;
  logic [SRAM_AW-1:0]  addr_q, addr_d;
  logic [HW_W-1:0]     dq_out_q, dq_out_d;
  logic                dq_oe_q, dq_oe_d;
  logic                ce_n_q, ce_n_d;
  logic                oe_n_q, oe_n_d;
  logic                we_n_q, we_n_d;

  logic                req;
  logic                last;
  logic                hi;
  logic [WORD_W-1:0]   off;

  assign req  = MEM_R_EN | MEM_W_EN;
  assign last = (cnt_q == LAST);
  assign off  = Address - WORD_W'(SRAM_BASE);

  assign ready = (state_q == IDLE && !req) || state_q == DONE;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    wr_d     = wr_q;
    word_d   = word_q;
    data_d   = data_q;
    result_d = result_q;
    unique case (state_q)
      IDLE: begin
        if (req) begin
          state_d = LOW;
          cnt_d   = '0;
          wr_d    = MEM_W_EN;
          word_d  = off[SRAM_AW:2];
          data_d  = Data;
        end
      end
      LOW: begin
        if (last) begin
          state_d = HIGH;
          cnt_d   = '0;
          if (!wr_q) result_d[15:0] = sram_dq_in;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      HIGH: begin
        if (last) begin
          state_d = DONE;
          cnt_d   = '0;
          if (!wr_q) result_d[31:16] = sram_dq_in;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      DONE: state_d = IDLE;
    endcase
  end

  // Strobes derive from next state so pins change only at clock edges.
  always_comb begin
    hi       = (state_d == HIGH);
    addr_d   = addr_q;
    dq_out_d = dq_out_q;
    dq_oe_d  = 1'b0;
    ce_n_d   = 1'b1;
    oe_n_d   = 1'b1;
    we_n_d   = 1'b1;
    if (state_d == LOW || state_d == HIGH) begin
      ce_n_d = 1'b0;
      addr_d = {word_d, hi};
      if (wr_d) begin
        dq_oe_d  = 1'b1;
        dq_out_d = hi ? data_d[31:16] : data_d[15:0];
        we_n_d   = (cnt_d == LAST);
      end else begin
        oe_n_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      wr_q     <= 1'b0;
      word_q   <= '0;
      data_q   <= '0;
      result_q <= '0;
      addr_q   <= '0;
      dq_out_q <= '0;
      dq_oe_q  <= 1'b0;
      ce_n_q   <= 1'b1;
      oe_n_q   <= 1'b1;
      we_n_q   <= 1'b1;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      wr_q     <= wr_d;
      word_q   <= word_d;
      data_q   <= data_d;
      result_q <= result_d;
      addr_q   <= addr_d;
      dq_out_q <= dq_out_d;
      dq_oe_q  <= dq_oe_d;
      ce_n_q   <= ce_n_d;
      oe_n_q   <= oe_n_d;
      we_n_q   <= we_n_d;
    end
  end

  assign MEM_result  = result_q;
  assign sram_addr   = addr_q;
  assign sram_dq_out = dq_out_q;
  assign sram_dq_oe  = dq_oe_q;
  assign sram_ce_n   = ce_n_q;
  assign sram_oe_n   = oe_n_q;
  assign sram_we_n   = we_n_q;

endmodule

// File: tb/tb_sram_mem_responder.sv
// Bench for sram_mem_responder: SRAM model plus word-level
// reference memory, directed and random accesses.
module tb_sram_mem_responder;

  localparam int W = 2;
  localparam logic [31:0] BASE = 32'd1024;
  localparam int DEPTH = 1 << 18;

  logic        clk = 1'b0;
  logic        rst;
  logic        r_en, w_en;
  logic [31:0] addr, data, res;
  logic        rdy;
  logic [17:0] s_addr;
  logic [15:0] dq_out, dq_in;
  logic        dq_oe, ce_n, oe_n, we_n;

  logic        w4;
  logic [31:0] res4;
  logic        rdy4;
  logic [17:0] s_addr4;
  logic [15:0] dq_out4;
  logic        dq_oe4, ce_n4, oe_n4, we_n4;

  logic [15:0] sram [DEPTH];
  logic [31:0] ref_mem [logic [17:0]];
  logic [31:0] exp_res;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  sram_mem_responder #(.WAIT_CYCLES(W)) u_dut (
    .clk(clk), .rst(rst),
    .MEM_R_EN(r_en), .MEM_W_EN(w_en),
    .Address(addr), .Data(data),
    .MEM_result(res), .ready(rdy),
    .sram_addr(s_addr), .sram_dq_out(dq_out),
    .sram_dq_oe(dq_oe), .sram_dq_in(dq_in),
    .sram_ce_n(ce_n), .sram_oe_n(oe_n), .sram_we_n(we_n)
  );

  sram_mem_responder #(.WAIT_CYCLES(4)) u_dut4 (
    .clk(clk), .rst(rst),
    .MEM_R_EN(1'b0), .MEM_W_EN(w4),
    .Address(32'd1024), .Data(32'h5555AAAA),
    .MEM_result(res4), .ready(rdy4),
    .sram_addr(s_addr4), .sram_dq_out(dq_out4),
    .sram_dq_oe(dq_oe4), .sram_dq_in(16'h1234),
    .sram_ce_n(ce_n4), .sram_oe_n(oe_n4), .sram_we_n(we_n4)
  );

  always_comb dq_in = (!ce_n && !oe_n) ? sram[s_addr] : 16'h0;

  always @(posedge clk)
    if (!ce_n && !we_n && dq_oe) sram[s_addr] <= dq_out;

  function automatic logic [15:0] fill(logic [17:0] a);
    return a[15:0] ^ 16'h5A5A;
  endfunction

  function automatic logic [31:0] exp_read(logic [17:0] lo);
    if (ref_mem.exists(lo)) return ref_mem[lo];
    return {fill(lo | 18'd1), fill(lo)};
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One full transaction; entered just after a posedge in IDLE.
  task automatic access(bit rd, bit wr, logic [31:0] a, logic [31:0] d);
    logic [17:0] lo;
    int hi, ph;
    lo = 18'(((a - BASE) >> 2) << 1);
    r_en = rd; w_en = wr; addr = a; data = d;
    @(negedge clk);
    chk("rdy_c0", 32'(rdy), 0);
    for (int k = 1; k <= 2 * W; k++) begin
      @(negedge clk);
      hi = (k > W) ? 1 : 0;
      ph = (k - 1) % W;
      chk("addr", 32'(s_addr), 32'(lo + 18'(hi)));
      chk("ce_n", 32'(ce_n), 0);
      chk("oe_n", 32'(oe_n), wr ? 1 : 0);
      chk("we_n", 32'(we_n), (wr && ph != W - 1) ? 0 : 1);
      chk("dq_oe", 32'(dq_oe), wr ? 1 : 0);
      if (wr) chk("dq_out", 32'(dq_out), hi ? 32'(d[31:16]) : 32'(d[15:0]));
      chk("rdy_mid", 32'(rdy), 0);
    end
    @(negedge clk);
    if (wr) ref_mem[lo] = d;
    else exp_res = exp_read(lo);
    chk("rdy_done", 32'(rdy), 1);
    chk("ce_done", 32'(ce_n), 1);
    chk("we_done", 32'(we_n), 1);
    chk("oe_done", 32'(oe_n), 1);
    chk("dqoe_done", 32'(dq_oe), 0);
    chk("result", res, exp_res);
    @(posedge clk); #1;
    r_en = 1'b0; w_en = 1'b0;
  endtask

  initial begin
    int first;
    for (int i = 0; i < DEPTH; i++) sram[i] = fill(18'(i));
    rst = 1'b0; r_en = 1'b0; w_en = 1'b0; w4 = 1'b0;
    addr = '0; data = '0; exp_res = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_rdy", 32'(rdy), 1);
    chk("rst_res", res, 0);
    chk("rst_addr", 32'(s_addr), 0);
    chk("rst_ce", 32'(ce_n), 1);
    chk("rst_oe", 32'(oe_n), 1);
    chk("rst_we", 32'(we_n), 1);
    chk("rst_dqoe", 32'(dq_oe), 0);
    chk("rst_dq", 32'(dq_out), 0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;

    access(0, 1, 32'd1024, 32'hDEADBEEF);
    access(1, 0, 32'd1024, 32'h0);
    chk("readback", res, 32'hDEADBEEF);
    access(1, 0, 32'd1032, 32'h0);
    access(1, 0, 32'd1020, 32'h0);
    access(0, 1, 32'd1028, 32'h11112222);
    access(1, 0, 32'd1028, 32'h0);
    chk("b2b", res, 32'h11112222);
    access(1, 1, 32'd1040, 32'hCAFEF00D);
    access(1, 0, 32'd1040, 32'h0);

    for (int i = 0; i < 24; i++) begin
      bit wr;
      logic [31:0] a;
      wr = 1'($urandom_range(0, 1));
      a = BASE - 32'd64 + 32'($urandom_range(0, 255));
      access(!wr, wr, a, $urandom);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end

    first = -1;
    w4 = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (rdy4) begin
        first = c;
        break;
      end
    end
    chk("wait4_lat", first, 9);
    @(posedge clk); #1;
    w4 = 1'b0;
    @(posedge clk); #1;

    access(0, 1, 32'd1024, 32'hABCD1234);
    access(1, 0, 32'd1024, 32'h0);
    w_en = 1'b1; addr = 32'd1100; data = 32'h01020304;
    @(negedge clk);
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("arst_ce", 32'(ce_n), 1);
    chk("arst_we", 32'(we_n), 1);
    chk("arst_oe", 32'(oe_n), 1);
    chk("arst_dqoe", 32'(dq_oe), 0);
    chk("arst_res", res, 0);
    chk("arst_rdy_req", 32'(rdy), 0);
    w_en = 1'b0;
    #1;
    chk("arst_rdy", 32'(rdy), 1);
    exp_res = '0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    access(1, 0, 32'd1200, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sram_mem_responder.md
Name: sram_mem_responder

Overview:
- Memory-side responder for the pipeline MEM stage: accepts the stage's read/write requests (R_EN, W_EN, Address, Data).
- Serves each request from an external 16-bit asynchronous SRAM as two half-word accesses with programmable wait states.
- Returns read data and a ready signal; the top level freezes IF/ID/EX/MEM while ready is low.
- Replaces the single-cycle data memory behind the EX_Reg/MEM_Reg boundary.

Parameters:
- SRAM_BASE, 1024: byte address mapped to SRAM word 0.
- WAIT_CYCLES, 2: cycles per half-word access; legal range 2..15.
- SRAM_AW, 18: SRAM address width in half-words.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous active-low reset.
- MEM_R_EN  input  1  read request from MEM stage; held stable until ready.
- MEM_W_EN  input  1  write request from MEM stage; held stable until ready.
- Address  input  32  byte address (ALU result).
- Data  input  32  write data (Val_Rm).
- MEM_result  output  32  read data, registered.
- ready  output  1  high = stage may advance this cycle.
- sram_addr  output  SRAM_AW  half-word address.
- sram_dq_out  output  16  write data to SRAM.
- sram_dq_oe  output  1  tri-state enable for dq, applied at the pad level.
- sram_dq_in  input  16  read data from SRAM.
- sram_ce_n  output  1  chip enable, active low.
- sram_oe_n  output  1  output enable, active low.
- sram_we_n  output  1  write enable, active low.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, counter=0.
  - MEM_result=0, sram_addr=0, sram_dq_out=0, sram_dq_oe=0.
  - sram_ce_n=1, sram_oe_n=1, sram_we_n=1.
  - ready follows its combinational rule (1 in IDLE with no request).
- Request: req = MEM_R_EN | MEM_W_EN. If both are set, the request is treated as a write.
- Word index: w = (Address - SRAM_BASE) >> 2, computed in 32 bits then truncated. Low half-word address = {w, 0}; high half-word address = {w, 1}, both truncated to SRAM_AW bits.
- No range check: addresses below SRAM_BASE wrap modulo 2^SRAM_AW.
- ready is combinational: ready = (state==IDLE && !req) || state==DONE.
- FSM states: IDLE, LOW, HIGH, DONE.
  - IDLE: if req, latch op/word/data, go to LOW with counter=0; else stay.
  - LOW:
    - ce_n=0; addr = low half.
    - Write: dq_oe=1, dq_out=Data[15:0], we_n=0 for counter < WAIT_CYCLES-1, we_n=1 on the last cycle (data hold).
    - Read: oe_n=0; sram_dq_in captured into MEM_result[15:0] on the last cycle.
    - After WAIT_CYCLES cycles, counter resets and state goes to HIGH.
  - HIGH: same as LOW with the high half; write uses Data[31:16]; read captures MEM_result[31:16]. Then go to DONE.
  - DONE: all strobes deasserted, dq_oe=0, ready=1. Next state is IDLE unconditionally; back-to-back requests are re-sampled in IDLE.
- Strobe outputs (ce_n/oe_n/we_n/addr/dq_out/dq_oe) are registered, i.e. driven from next-state logic so they are glitch-free.
- Latency: request first seen in cycle 0 → ready=1 in cycle 1+2*WAIT_CYCLES (cycle 5 at default). Ready stays low in all intermediate cycles.
- MEM_result holds its last read value through writes and idle periods.
- MEM_result for a read is valid in the DONE cycle, so MEM_Reg captures it on that edge.
- Request deasserted mid-access (protocol violation): the access completes anyway, using the latched values.
- Reset mid-access: strobes go inactive immediately; the SRAM contents of a partial write are undefined.

Decomposition:
- Shared package arm_mem_pkg holds:
  - state enum (IDLE, LOW, HIGH, DONE);
  - SRAM_BASE_DEFAULT;
  - SRAM half-word width 16;
  - word width 32.
- No sub-module: the FSM and its 4-bit wait counter fit in one module.

Test Plan:
- Reset: hold rst=0 mid-write → ce_n=we_n=oe_n=1, dq_oe=0, MEM_result=0 immediately (asynchronously); ready=1 once no request is present.
- Write: W_EN=1, Address=1024, Data=0xDEADBEEF, WAIT=2 →
  - addr=0 with dq=0xBEEF in cycles 1-2, addr=1 with dq=0xDEAD in cycles 3-4;
  - we_n low in cycles 1 and 3 only;
  - ready=1 in cycle 5 only.
- Read-back: R_EN=1, Address=1024, SRAM model returns the written data → MEM_result=0xDEADBEEF in cycle 5; ready low in cycles 0-4.
- Address map: R_EN at Address=1032 → sram_addr sequence 4, 5. Address=1020 → word 0x3FFFF, so addresses 0x3FFFE, 0x3FFFF (wrap).
- Back-to-back: write 0x11112222 at Address=1028, then a read at Address=1028 presented on the cycle after DONE → read starts from IDLE, returns 0x11112222, and no cycle is lost beyond one IDLE.
- Both enables, and WAIT=4:
  - R_EN=W_EN=1 → performs a write, MEM_result unchanged.
  - Rebuild with WAIT_CYCLES=4 → ready appears at cycle 9.
